// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the single-clock FIFO.
package fifo_pkg;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic int count_w(input int asize);
    return asize + 1;
  endfunction

  function automatic bit afull_th_ok(input int asize, input int th);
    return (th >= 1) && (th <= (1 << asize));
  endfunction

  function automatic bit aempty_th_ok(input int asize, input int th);
    return (th >= 0) && (th <= (1 << asize) - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port, read port either combinational (FWFT) or registered.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (FWFT != 0) begin : g_async
    assign rdata = mem[raddr];
  end else begin : g_reg
    // Only the output register is cleared; the array itself is never reset.
    always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, sticky
// overflow/underflow flags and selectable standard or FWFT read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 5,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        winc,
  input  logic [DSIZE-1:0]            wdata,
  input  logic                        rinc,
  output logic [DSIZE-1:0]            rdata,
  output logic                        rvalid,
  output logic                        wfull,
  output logic                        rempty,
  output logic                        walmost_full,
  output logic                        ralmost_empty,
  output logic [count_w(ASIZE)-1:0]   count,
  input  logic                        clr_err,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int             CW       = count_w(ASIZE);
  localparam logic [CW-1:0]  ONE      = CW'(1);
  localparam logic [CW-1:0]  AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0]  AEMPTY_C = CW'(AEMPTY_TH);

  if (!afull_th_ok(ASIZE, AFULL_TH)) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH out of range 1..2**ASIZE");
  end
  if (!aempty_th_ok(ASIZE, AEMPTY_TH)) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH out of range 0..2**ASIZE-1");
  end

  logic [CW-1:0]    wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic             wr_ok, rd_ok;
  logic [DSIZE-1:0] mem_rdata;

  // Acceptance is gated by the registered flags, so full+rinc frees a slot
  // but the coincident write is still refused that cycle.
  always_comb begin
    wr_ok     = winc & ~wfull;
    rd_ok     = rinc & ~rempty;
    wptr_nxt  = wr_ok ? wptr + ONE : wptr;
    rptr_nxt  = rd_ok ? rptr + ONE : rptr;
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      count         <= count_nxt;
      wfull         <= (wptr_nxt[ASIZE] != rptr_nxt[ASIZE]) &&
                       (wptr_nxt[ASIZE-1:0] == rptr_nxt[ASIZE-1:0]);
      rempty        <= (wptr_nxt == rptr_nxt);
      walmost_full  <= (count_nxt >= AFULL_C);
      ralmost_empty <= (count_nxt <= AEMPTY_C);
      // A new error event outranks a coincident clear.
      overflow      <= (winc & wfull)  | (overflow  & ~clr_err);
      underflow     <= (rinc & rempty) | (underflow & ~clr_err);
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is masked while empty so a stale or in-flight slot never leaks out.
    assign rvalid = ~rempty;
    assign rdata  = rempty ? '0 : mem_rdata;
  end else begin : g_std
    logic rd_vld;
    always_ff @(posedge clk) begin
      if (rst) rd_vld <= 1'b0;
      else     rd_vld <= rd_ok;
    end
    assign rvalid = rd_vld;
    assign rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share one stimulus stream.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst, winc, rinc, clr_err;
  logic [7:0] wdata;

  logic [7:0] rdata, rdata_f;
  logic       rvalid, wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic       rvalid_f, wfull_f, rempty_f, walmost_full_f, ralmost_empty_f, overflow_f, underflow_f;
  logic [3:0] count, count_f;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic [7:0] expq[$];
  logic       m_ovf, m_unf, m_rvalid;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
    .rvalid(rvalid), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
    .ralmost_empty(ralmost_empty), .count(count), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata_f),
    .rvalid(rvalid_f), .wfull(wfull_f), .rempty(rempty_f), .walmost_full(walmost_full_f),
    .ralmost_empty(ralmost_empty_f), .count(count_f), .clr_err(clr_err),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  // {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow, rvalid}
  function automatic logic [6:0] exp_flags();
    int sz = mq.size();
    return {sz == 8, sz == 0, sz >= 6, sz <= 2, m_ovf, m_unf, m_rvalid};
  endfunction

  // One clock of stimulus; the reference model advances in step with it.
  task automatic drive(input logic w, input logic [7:0] wd, input logic r, input logic ce);
    logic wok, rok;
    winc = w; wdata = wd; rinc = r; clr_err = ce;
    wok = w && (mq.size() != 8);
    rok = r && (mq.size() != 0);
    m_ovf = (w && mq.size() == 8) || (m_ovf && !ce);
    m_unf = (r && mq.size() == 0) || (m_unf && !ce);
    if (rok) expq.push_back(mq.pop_front());
    if (wok) mq.push_back(wd);
    m_rvalid = rok;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst = 1'b1; winc = w; rinc = r; wdata = 8'h77; clr_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    mq.delete(); expq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    do_reset(1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    got = {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow, rvalid};
    checks++;
    if (got !== 7'b0101000) begin
      errors++; $display("FAIL reset_flags: got %b want %b", got, 7'b0101000);
    end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    checks++;
    if ({rvalid_f, rempty_f, rdata_f} !== {1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_fwft: got rvalid=%b rempty=%b rdata=%h want 0 1 00",
                         rvalid_f, rempty_f, rdata_f);
    end
  endtask

  task automatic test_fill_drain();
    logic [6:0] got;
    logic [7:0] exp;
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      got = {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow, rvalid};
      checks++;
      if (got !== exp_flags()) begin
        errors++; $display("FAIL fill_flags[%0d]: got %b want %b", i, got, exp_flags());
      end
      checks++;
      if (count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      got = {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow, rvalid};
      checks++;
      if (got !== exp_flags()) begin
        errors++; $display("FAIL drain_flags[%0d]: got %b want %b", i, got, exp_flags());
      end
      if (m_rvalid && expq.size() > 0) begin
        exp = expq.pop_front();
        checks++;
        if (rdata !== exp) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, rdata, exp); end
      end
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    checks++;
    if ({count, overflow, wfull, rvalid} !== {4'(mq.size()), m_ovf, 1'b0, 1'b1}) begin
      errors++; $display("FAIL full_simul: got count=%0d ovf=%b wfull=%b rvalid=%b want %0d %b 0 1",
                         count, overflow, wfull, rvalid, mq.size(), m_ovf);
    end
    exp = expq.pop_front();
    checks++;
    if (rdata !== exp) begin errors++; $display("FAIL full_simul_data: got %h want %h", rdata, exp); end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_sticky: got %b want %b", overflow, m_ovf); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_clear: got %b want %b", overflow, m_ovf); end
    // The rejected 0xEE must not have landed: the remaining seven come out in order.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      exp = expq.pop_front();
      checks++;
      if (rdata !== exp) begin errors++; $display("FAIL full_tail[%0d]: got %h want %h", i, rdata, exp); end
    end
    checks++;
    if ({rempty, count} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL full_tail_empty: got rempty=%b count=%0d want 1 0", rempty, count);
    end
  endtask

  task automatic test_empty_simul();
    logic [7:0] exp;
    do_reset(1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if ({count, underflow, rvalid, rempty} !== {4'd1, m_unf, 1'b0, 1'b0}) begin
      errors++; $display("FAIL empty_simul: got count=%0d unf=%b rvalid=%b rempty=%b want 1 %b 0 0",
                         count, underflow, rvalid, rempty, m_unf);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    exp = expq.pop_front();
    checks++;
    if ({rvalid, rdata} !== {1'b1, exp}) begin
      errors++; $display("FAIL empty_simul_data: got rvalid=%b rdata=%h want 1 %h", rvalid, rdata, exp);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (underflow !== m_unf) begin errors++; $display("FAIL unf_set_wins: got %b want %b", underflow, m_unf); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (underflow !== m_unf) begin errors++; $display("FAIL unf_clear: got %b want %b", underflow, m_unf); end
  endtask

  task automatic test_fwft();
    do_reset(1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++;
    if ({rvalid_f, rdata_f} !== {1'b1, mq[0]}) begin
      errors++; $display("FAIL fwft_show: got rvalid=%b rdata=%h want 1 %h", rvalid_f, rdata_f, mq[0]);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({rvalid_f, rdata_f, count_f} !== {1'b1, 8'h5A, 4'd1}) begin
      errors++; $display("FAIL fwft_hold: got rvalid=%b rdata=%h count=%0d want 1 5a 1", rvalid_f, rdata_f, count_f);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({rvalid_f, rempty_f} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL fwft_pop: got rvalid=%b rempty=%b want 0 1", rvalid_f, rempty_f);
    end
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({rvalid_f, rdata_f} !== {1'b1, mq[0]}) begin
      errors++; $display("FAIL fwft_next: got rvalid=%b rdata=%h want 1 %h", rvalid_f, rdata_f, mq[0]);
    end
  endtask

  task automatic test_wrap_reset();
    logic [6:0] got;
    logic [7:0] exp;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'hB0 + 8'(i)), 1'b1, 1'b0);
      got = {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow, rvalid};
      exp = expq.pop_front();
      checks++;
      if ({got, count, rdata} !== {exp_flags(), 4'd3, exp}) begin
        errors++; $display("FAIL wrap[%0d]: got flags=%b count=%0d rdata=%h want %b 3 %h",
                           i, got, count, rdata, exp_flags(), exp);
      end
      checks++;
      if (rdata_f !== mq[0]) begin errors++; $display("FAIL wrap_fwft[%0d]: got %h want %h", i, rdata_f, mq[0]); end
    end
    do_reset(1'b1, 1'b1);
    got = {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow, rvalid};
    checks++;
    if ({got, count, rdata} !== {7'b0101000, 4'd0, 8'h00}) begin
      errors++; $display("FAIL midstream_reset: got flags=%b count=%0d rdata=%h want 0101000 0 00", got, count, rdata);
    end
    checks++;
    if ({rvalid_f, rempty_f, count_f} !== {1'b0, 1'b1, 4'd0}) begin
      errors++; $display("FAIL midstream_reset_fwft: got rvalid=%b rempty=%b count=%0d want 0 1 0",
                         rvalid_f, rempty_f, count_f);
    end
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    m_ovf = 1'b0; m_unf = 1'b0; m_rvalid = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_empty_simul();
    test_fwft();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock successor to the dual-clock FIFO top, for datapaths where producer and consumer share one clock.
- Synchronizers and Gray pointers are removed. Adds a fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Used as the local elastic buffer between pipeline stages in the same clock domain.

Parameters:
- DSIZE, 32, data word width in bits.
- ASIZE, 5, address width; depth = 2**ASIZE.
- AFULL_TH, 28, walmost_full asserts when count >= AFULL_TH (legal range 1..2**ASIZE).
- AEMPTY_TH, 4, ralmost_empty asserts when count <= AEMPTY_TH (legal range 0..2**ASIZE-1).
- FWFT, 0, read mode: 0 = registered read (standard), 1 = first-word-fall-through.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- winc, input, 1, write request.
- wdata, input, DSIZE, write data.
- rinc, input, 1, read request (pop).
- rdata, output, DSIZE, read data.
- rvalid, output, 1, rdata holds a valid popped/head word.
- wfull, output, 1, FIFO full.
- rempty, output, 1, FIFO empty.
- walmost_full, output, 1, count >= AFULL_TH.
- ralmost_empty, output, 1, count <= AEMPTY_TH.
- count, output, ASIZE+1, number of stored words, 0..2**ASIZE.
- clr_err, input, 1, clears the sticky error flags.
- overflow, output, 1, sticky: a write was attempted while full.
- underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Reset: synchronous, applied on the rising clk edge while rst=1. It overrides every other input, including a mid-burst operation.
  - Post-reset values: pointers=0, count=0, rempty=1, wfull=0, ralmost_empty=1 (because AEMPTY_TH >= 0), walmost_full=0, overflow=0, underflow=0, rvalid=0, rdata=0.
  - Memory contents are not reset.
- Pointers: wptr and rptr are ASIZE+1-bit binary counters; waddr/raddr are their low ASIZE bits, wrapping naturally.
  - Full: MSBs differ and low bits are equal.
  - Empty: the pointers are equal.
- Write acceptance: wr_ok = winc & ~wfull. On an accepted write, mem[waddr] <= wdata and wptr increments.
- Read acceptance: rd_ok = rinc & ~rempty. On an accepted read, rptr increments.
- Flags: wfull, rempty, walmost_full, ralmost_empty and count are all registered and reflect state after the current edge.
- count update: count_next = count + wr_ok - rd_ok.
  - Both accepted: count is unchanged.
  - Only arithmetic exactly representable in ASIZE+1 bits is used.
- Simultaneous winc and rinc when full: the read is accepted and the write is rejected (flag-based gating). overflow is set and count goes 2**ASIZE -> 2**ASIZE-1.
- Simultaneous winc and rinc when empty: the write is accepted and the read is rejected. underflow is set and count goes 0 -> 1.
- Error flags:
  - overflow sets on winc & wfull; underflow sets on rinc & rempty.
  - Both are sticky until rst, or until clr_err=1 at an edge.
  - If clr_err coincides with a new error event, the set wins.
  - A rejected access never alters pointers, memory or count.
- Standard mode (FWFT=0):
  - rd_ok at edge N: rdata <= mem[raddr] at edge N and rvalid=1 for that cycle (1-cycle read latency).
  - Otherwise rvalid=0 and rdata holds its last value.
- FWFT mode (FWFT=1):
  - rdata continuously shows mem[raddr] (the head word), and rvalid = ~rempty.
  - rd_ok pops the head; the next word appears after the edge.
  - A word written at edge N is visible on rdata, with rvalid=1, after edge N (0-cycle read latency).
  - A write to the slot being read while empty is not visible until rempty deasserts.
- Wrap-around: after 2**ASIZE writes and reads, the pointers wrap through the MSB and the full/empty decode stays correct.

Decomposition:
- Shared package fifo_pkg holds:
  - localparams DEPTH = 2**ASIZE;
  - the count width function (ASIZE+1);
  - the threshold legality checks (elaboration-time assertions that AFULL_TH and AEMPTY_TH are in range).
- One sub-module, sync_fifo_mem: dual-port RAM with a write enable plus an asynchronous read port (FWFT) or a registered read port (standard), selected by the FWFT parameter.
- Pointer, count, flag and error logic stays in sync_fifo_flags.

Test Plan:
All scenarios use ASIZE=3 (depth 8), AFULL_TH=6, AEMPTY_TH=2, DSIZE=8.
- Reset then idle -> rempty=1, ralmost_empty=1, wfull=0, count=0, overflow=0, underflow=0, rvalid=0.
- Write 0x01..0x08 on 8 consecutive cycles, then read 8, FWFT=0:
  - count steps 1..8;
  - walmost_full rises when count=6;
  - wfull rises after the 8th write;
  - reads return 0x01..0x08 one cycle after each rinc;
  - rempty=1 after the 8th read.
- Full, then winc=rinc=1 for one cycle -> read accepted and write rejected; count=7, overflow=1 (sticky). Pulse clr_err -> overflow=0.
- Empty, then winc=rinc=1 with wdata=0xAA -> count=1, underflow=1; next read returns 0xAA.
- FWFT=1: write 0x5A at edge N -> after edge N rdata=0x5A, rvalid=1 with no rinc; rinc pops it and rempty=1 and rvalid=0 after the next edge.
- Wrap and reset: run 20 write/read pairs at steady count=3 (pointers wrap twice; data stays in order and the flags stay stable), then assert rst mid-stream -> all outputs return to their reset values on the next edge.
